// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam int         WORD_BYTES = 4;
  localparam logic [1:0] LANE_LAST  = 2'(WORD_BYTES - 1);

  // States in which the loader is willing to take a stream byte.
  function automatic logic state_accepts(input state_e s);
    return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted payload bytes little-endian into 32-bit words; pulses
// word_valid for one cycle after the fourth byte of each word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [1:0]  lane,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] asm_q, asm_d;
  logic        word_valid_q, word_valid_d;
  logic [31:0] word_q, word_d;

  // Next-state: store bytes 0..2 in the assembly register, emit word on byte 3.
  always_comb begin
    lane_d       = lane_q;
    asm_d        = asm_q;
    word_valid_d = 1'b0;
    word_d       = word_q;
    if (byte_valid) begin
      if (lane_q == LANE_LAST) begin
        word_d       = {byte_in, asm_q};
        word_valid_d = 1'b1;
        lane_d       = 2'd0;
      end else begin
        case (lane_q)
          2'd0:    asm_d[7:0]   = byte_in;
          2'd1:    asm_d[15:8]  = byte_in;
          default: asm_d[23:16] = byte_in;
        endcase
        lane_d = lane_q + 2'd1;
      end
    end
  end

  // Packer registers; reset discards any partially assembled word.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q       <= 2'd0;
      asm_q        <= 24'd0;
      word_valid_q <= 1'b0;
      word_q       <= 32'd0;
    end else begin
      lane_q       <= lane_d;
      asm_q        <= asm_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
    end
  end

  assign lane       = lane_q;
  assign word_valid = word_valid_q;
  assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a byte-stream program image into instruction memory and keeps the
// core in reset until a complete image with a matching checksum arrived.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              in_ready_q, in_ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_rst_q, cpu_rst_d;

  logic              accept;
  logic [15:0]       n_hdr;
  logic              hdr_bad;
  logic [ADDR_W:0]   wc_inc;
  logic [1:0]        pk_lane;

  assign accept  = in_valid && in_ready_q;
  assign n_hdr   = {in_byte, cnt_q[7:0]};
  assign hdr_bad = (n_hdr == 16'd0) || ({16'd0, n_hdr} > 32'(DEPTH));
  assign wc_inc  = word_count_q + {{ADDR_W{1'b0}}, 1'b1};

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (accept && (state_q == S_DATA)),
    .byte_in    (in_byte),
    .lane       (pk_lane),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  // Loader FSM next-state: header decode, word counting, checksum verdict.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    word_count_d = word_count_q;
    imem_addr_d  = imem_addr_q;
    case (state_q)
      S_HDR0: begin
        if (accept) begin
          cnt_d[7:0] = in_byte;
          state_d    = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          cnt_d[15:8] = in_byte;
          state_d     = hdr_bad ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          sum_d = sum_q + in_byte;
          if (pk_lane == LANE_LAST) begin
            // Address is the pre-increment count; the packer strobes next cycle.
            imem_addr_d  = word_count_q[ADDR_W-1:0];
            word_count_d = wc_inc;
            if (16'(wc_inc) == cnt_q) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (in_byte == sum_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
    in_ready_d = state_accepts(state_d);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    cpu_rst_d  = (state_d != S_DONE);
  end

  // Loader state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HDR0;
      cnt_q        <= 16'd0;
      sum_q        <= 8'd0;
      word_count_q <= '0;
      imem_addr_q  <= '0;
      in_ready_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cpu_rst_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      word_count_q <= word_count_d;
      imem_addr_q  <= imem_addr_d;
      in_ready_q   <= in_ready_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cpu_rst_q    <= cpu_rst_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_addr  = imem_addr_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed/randomized bench for imem_loader with a stream-level reference model.
module tb_imem_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_byte = 8'd0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int accepts     = 0;
  int acc_edge[$];
  int wr_cyc[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  // Reference-model results
  logic [31:0] m_words[$];
  bit          m_done;
  bit          m_err;

  bq_t stream;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Cycle counter (number of rising edges so far).
  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: logs accepted bytes and memory writes.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      accepts++;
      acc_edge.push_back(cyc + 1);
    end
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    accepts = 0;
    acc_edge.delete();
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Reference model: decode a whole stream into the expected image and verdict.
  function automatic void model(input bq_t s);
    int n;
    int sum;
    m_words.delete();
    n = int'({s[1], s[0]});
    if (n == 0 || n > DEPTH) begin
      m_done = 1'b0;
      m_err  = 1'b1;
      return;
    end
    sum = 0;
    for (int i = 0; i < n; i++) begin
      m_words.push_back({s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
      for (int k = 0; k < 4; k++) sum += int'(s[2+4*i+k]);
    end
    m_done = (int'(s[2+4*n]) == (sum % 256));
    m_err  = !m_done;
  endfunction

  // Build a stream from a word list; csum_delta perturbs the trailing checksum.
  function automatic bq_t build_stream(input logic [31:0] w[$], input int csum_delta);
    bq_t s;
    int  sum;
    logic [15:0] n;
    logic [31:0] cw;
    n   = 16'(w.size());
    sum = 0;
    s.push_back(n[7:0]);
    s.push_back(n[15:8]);
    for (int i = 0; i < w.size(); i++) begin
      cw = w[i];
      for (int k = 0; k < 4; k++) begin
        s.push_back(cw[8*k +: 8]);
        sum += int'(cw[8*k +: 8]);
      end
    end
    s.push_back(8'((sum + csum_delta) % 256));
    return s;
  endfunction

  function automatic bq_t rand_stream(input int n, input int csum_delta);
    logic [31:0] w[$];
    for (int i = 0; i < n; i++) w.push_back($urandom);
    return build_stream(w, csum_delta);
  endfunction

  // Offer one byte, with optional random leading bubbles, until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int   g;
    int   tries;
    logic rdy;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_byte  = b;
    tries    = 0;
    rdy      = 1'b0;
    while (!rdy && tries < 50) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      tries++;
    end
    in_valid = 1'b0;
    check("ready_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Drive a full stream and compare everything against the model.
  task automatic run_load(input string name, input bq_t s, input int gap_max);
    int n;
    model(s);
    clear_logs();
    for (int i = 0; i < s.size() - 1; i++) send_byte(s[i], gap_max);
    check({name, "_cpu_rst_before_last"}, 32'(cpu_rst), 32'd1);
    send_byte(s[s.size()-1], gap_max);
    // Verdict visible in the cycle right after the final accept
    check({name, "_cpu_rst_at_end"}, 32'(cpu_rst), 32'(!m_done));
    check({name, "_done_at_end"}, 32'(done), 32'(m_done));
    check({name, "_err_at_end"}, 32'(err), 32'(m_err));
    in_valid = 1'b1;
    in_byte  = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = m_words.size();
    check({name, "_n_writes"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      check({name, "_wr_addr"}, 32'(wr_addr[i]), 32'(i));
      check({name, "_wr_data"}, wr_data[i], m_words[i]);
    end
    check({name, "_accepts"}, 32'(accepts), 32'(s.size()));
    check({name, "_done"}, 32'(done), 32'(m_done));
    check({name, "_err"}, 32'(err), 32'(m_err));
    check({name, "_cpu_rst"}, 32'(cpu_rst), 32'(!m_done));
    check({name, "_word_count"}, 32'(word_count), 32'(n));
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] w[$];

    // 1. Known two-instruction image, correct checksum
    do_reset();
    w.delete();
    w.push_back(32'h00500093);
    w.push_back(32'h00A00113);
    stream = build_stream(w, 0);
    check("t1_csum_byte", 32'(stream[10]), 32'h97);
    run_load("t1", stream, 2);

    // 2. Same image, checksum off by one
    do_reset();
    stream = build_stream(w, 1);
    run_load("t2", stream, 1);

    // 3. Bad headers: N=0 and N=DEPTH+1
    do_reset();
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h00);
    run_load("t3a", stream, 1);
    do_reset();
    stream.delete();
    stream.push_back(8'h01);
    stream.push_back(8'h01);
    run_load("t3b", stream, 0);

    // 4. Full-depth random image with random bubbles
    do_reset();
    stream = rand_stream(DEPTH, 0);
    run_load("t4", stream, 2);
    if (wr_addr.size() > 0) check("t4_last_addr", 32'(wr_addr[wr_addr.size()-1]), 32'd255);

    // 5. Reset after 6 payload bytes of an N=3 load, then a fresh N=1 load
    do_reset();
    clear_logs();
    stream = rand_stream(3, 0);
    for (int i = 0; i < 8; i++) send_byte(stream[i], 1);
    check("t5_pre_writes", 32'(wr_addr.size()), 32'd1);
    do_reset();
    stream = rand_stream(1, 0);
    run_load("t5", stream, 1);

    // 6. Back-to-back valid, N=1, extra bytes offered after the checksum
    do_reset();
    clear_logs();
    stream = rand_stream(1, 0);
    model(stream);
    in_valid = 1'b1;
    for (int i = 0; i < stream.size(); i++) begin
      in_byte = stream[i];
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      in_byte = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("t6_accepts", 32'(accepts), 32'd7);
    check("t6_n_writes", 32'(wr_cyc.size()), 32'd1);
    if (wr_cyc.size() > 0 && acc_edge.size() > 5)
      check("t6_we_timing", 32'(wr_cyc[0]), 32'(acc_edge[5]));
    if (wr_data.size() > 0) check("t6_wr_data", wr_data[0], m_words[0]);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_done", 32'(done), 32'd1);
    check("t6_cpu_rst", 32'(cpu_rst), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
